// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic array front-end.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } feeder_state_t;

  localparam int DATA_W_DEF = 8;

  // Cycles of zero injection needed to push the last real vector out of an NxN array.
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Diagonal skew: row i of the slot appears on the array edge after i+1 register stages.
module skew_line #(
  parameter int N      = 2,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N*DATA_W-1:0] slot_data,
  input  logic [N-1:0]        slot_tag,
  output logic [N*DATA_W-1:0] a_row,
  output logic [N-1:0]        a_tag
);

  for (genvar i = 0; i < N; i++) begin : g_row
    // Each stage carries {tag, data} for this row only.
    logic [DATA_W:0] sr [i+1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) sr[k] <= '0;
      end else begin
        sr[0] <= {slot_tag[i], slot_data[i*DATA_W +: DATA_W]};
        for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
      end
    end

    assign a_row[i*DATA_W +: DATA_W] = sr[i][DATA_W-1:0];
    assign a_tag[i]                  = sr[i][DATA_W];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Weight loader, activation skewer and drain sequencer for a weight-stationary NxN array.
// Handshakes: a beat transfers on a rising edge where valid and ready are both high;
// ready is a pure decode of registered state and never looks at valid.
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_vecs,
  input  logic                s_w_valid,
  output logic                s_w_ready,
  input  logic [N*DATA_W-1:0] s_w_data,
  input  logic                s_a_valid,
  output logic                s_a_ready,
  input  logic [N*DATA_W-1:0] s_a_data,
  output logic [N-1:0]        load_weight,
  output logic [N*DATA_W-1:0] weight_row,
  output logic                pe_valid,
  output logic [N*DATA_W-1:0] a_row,
  output logic [N-1:0]        a_tag,
  output logic                busy,
  output logic                done,
  output feeder_state_t       dbg_state
);

  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam int DRN_W = $clog2(drain_len(N) + 1);

  feeder_state_t       state, next_state;
  logic [CNT_W-1:0]    num_lat, accepted;
  logic [ROW_W-1:0]    row_cnt;
  logic [DRN_W-1:0]    drain_cnt;
  logic                w_fire, a_fire, last_row, last_vec, drain_end;
  logic [N*DATA_W-1:0] slot_data;
  logic [N-1:0]        slot_tag;

  assign w_fire    = s_w_valid && s_w_ready;
  assign a_fire    = s_a_valid && s_a_ready;
  assign last_row  = (row_cnt == ROW_W'(N - 1));
  assign last_vec  = (accepted == num_lat - CNT_W'(1));
  assign drain_end = (drain_cnt == '0);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD_W;
      LOAD_W:  if (w_fire && last_row) next_state = (num_lat == '0) ? DONE : STREAM;
      STREAM:  if (a_fire && last_vec) next_state = DRAIN;
      DRAIN:   if (drain_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_w_ready = 1'b0;
    s_a_ready = 1'b0;
    pe_valid  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      LOAD_W: s_w_ready = 1'b1;
      STREAM: begin
        pe_valid  = 1'b1;
        s_a_ready = (accepted < num_lat);
      end
      DRAIN:  pe_valid = 1'b1;
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_lat   <= '0;
      accepted  <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        num_lat  <= num_vecs;
        accepted <= '0;
        row_cnt  <= '0;
      end
      if (w_fire) row_cnt <= row_cnt + 1'b1;
      if (a_fire) accepted <= accepted + 1'b1;
      if (state == STREAM && next_state == DRAIN)
        drain_cnt <= DRN_W'(drain_len(N) - 1);
      else if (state == DRAIN && !drain_end)
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Weight strobe and row are registered so each beat is presented for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_weight <= '0;
      weight_row  <= '0;
    end else begin
      load_weight <= w_fire ? (N'(1) << row_cnt) : '0;
      weight_row  <= w_fire ? s_w_data : '0;
    end
  end

  // Only a real handshake feeds data; every other cycle injects a tagged-off zero slot.
  always_comb begin
    slot_data = a_fire ? s_a_data : '0;
    slot_tag  = a_fire ? '1 : '0;
  end

  skew_line #(.N(N), .DATA_W(DATA_W)) u_skew (
    .clk       (clk),
    .reset     (reset),
    .slot_data (slot_data),
    .slot_tag  (slot_tag),
    .a_row     (a_row),
    .a_tag     (a_tag)
  );

endmodule
